// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, fetches one instruction
// at a time over a req/gnt/rvalid interface, and redirects on a taken branch.
module if_fetch_stage #(
  parameter int                XLEN      = 64,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PC_Write,
  input  logic            IF_ID_Write,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [31:0]     IF_ID_instr,
  output logic            IF_ID_valid
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_KILL} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic              if_valid_q, if_valid_d;
  logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
  logic [31:0]       buf_instr_q, buf_instr_d;

  logic              adv;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   target_aligned;
  logic              unused_target_lsbs;

  assign adv                = PC_Write & IF_ID_Write;
  assign pc_plus4           = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
  assign target_aligned     = {branch_target[XLEN-1:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];

  assign imem_req    = (state_q == S_FETCH) & ~flush & ~reset;
  assign imem_addr   = pc_q;
  assign IF_ID_pc    = if_pc_q;
  assign IF_ID_instr = if_instr_q;
  assign IF_ID_valid = if_valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;

    if (flush) begin
      if_pc_d     = '0;
      if_instr_d  = NOP_INSTR;
      if_valid_d  = 1'b0;
      pc_d        = target_aligned;
      buf_pc_d    = '0;
      buf_instr_d = NOP_INSTR;
      // A granted fetch still owes us a response; it must be swallowed in KILL.
      unique case (state_q)
        S_WAIT:  state_d = S_KILL;
        S_KILL:  state_d = imem_rvalid ? S_FETCH : S_KILL;
        default: state_d = S_FETCH;
      endcase
    end else begin
      if (adv) begin
        if_pc_d    = pc_q;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end
      unique case (state_q)
        S_FETCH: begin
          if (imem_gnt) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (adv) begin
              if_pc_d    = pc_q;
              if_instr_d = imem_rdata;
              if_valid_d = 1'b1;
              pc_d       = pc_plus4;
              state_d    = S_FETCH;
            end else begin
              buf_pc_d    = pc_q;
              buf_instr_d = imem_rdata;
              state_d     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (adv) begin
            if_pc_d    = buf_pc_q;
            if_instr_d = buf_instr_q;
            if_valid_d = 1'b1;
            pc_d       = pc_plus4;
            state_d    = S_FETCH;
          end
        end
        S_KILL: begin
          if (imem_rvalid) state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      if_pc_q     <= '0;
      if_instr_q  <= NOP_INSTR;
      if_valid_q  <= 1'b0;
      buf_pc_q    <= '0;
      buf_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic, all checked
// every cycle against a flag-based transaction model and an instruction-memory model.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, PC_Write, IF_ID_Write, flush, imem_gnt, imem_rvalid;
  logic [63:0] branch_target;
  logic [31:0] imem_rdata;
  logic        imem_req, IF_ID_valid;
  logic [63:0] imem_addr, IF_ID_pc;
  logic [31:0] IF_ID_instr;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .flush(flush), .branch_target(branch_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr),
    .IF_ID_valid(IF_ID_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pending = a live fetch awaits its response, discard = an outstanding
  // response must be dropped, held = a fetched instruction waits for the stall to end.
  logic [63:0] m_pc = 64'h0, m_ifpc = 64'h0;
  logic [31:0] m_ifinstr = NOP, m_hbuf = NOP;
  bit          m_ifvalid = 0, m_pending = 0, m_discard = 0, m_held = 0;

  bit          mem_out = 0;
  int          mem_wait = 0;
  logic [31:0] mem_data = 32'h0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic bit exp_req();
    return !m_pending && !m_discard && !m_held && !flush && !reset;
  endfunction

  task automatic deliver(input logic [31:0] instr);
    m_ifpc    = m_pc;
    m_ifinstr = instr;
    m_ifvalid = 1;
    $display("[TB] t=%0t deliver pc=%h instr=%h", $time, m_pc, instr);
    m_pc      = m_pc + 64'd4;
  endtask

  task automatic model_update(input bit rq);
    bit adv;
    adv = PC_Write && IF_ID_Write;
    if (reset) begin
      m_pc = 64'h0; m_ifpc = 64'h0; m_ifinstr = NOP; m_ifvalid = 0;
      m_pending = 0; m_discard = 0; m_held = 0;
    end else if (flush) begin
      m_ifpc = 64'h0; m_ifinstr = NOP; m_ifvalid = 0;
      m_pc   = branch_target & ~64'h3;
      m_held = 0;
      if (m_pending) begin
        m_pending = 0;
        m_discard = 1;
      end else if (m_discard && imem_rvalid) begin
        m_discard = 0;
      end
    end else begin
      if (m_pending && imem_rvalid) begin
        m_pending = 0;
        if (adv) deliver(imem_rdata);
        else begin
          m_held = 1;
          m_hbuf = imem_rdata;
        end
      end else if (m_held && adv) begin
        m_held = 0;
        deliver(m_hbuf);
      end else if (adv) begin
        m_ifpc = m_pc; m_ifinstr = NOP; m_ifvalid = 0;
      end
      if (m_discard && imem_rvalid) m_discard = 0;
      if (rq && imem_gnt) m_pending = 1;
    end
  endtask

  task automatic mem_update(input bit rq);
    if (reset) mem_out = 0;
    else begin
      if (mem_out) begin
        if (imem_rvalid) mem_out = 0;
        else if (mem_wait > 0) mem_wait--;
      end
      if (rq && imem_gnt) begin
        mem_out  = 1;
        mem_wait = $urandom_range(0, 2);
        mem_data = $urandom;
      end
    end
  endtask

  task automatic cycle();
    bit rq;
    @(negedge clk);
    check("imem_req",    {63'h0, imem_req},    {63'h0, exp_req()});
    check("imem_addr",   imem_addr,            m_pc);
    check("IF_ID_pc",    IF_ID_pc,             m_ifpc);
    check("IF_ID_instr", {32'h0, IF_ID_instr}, {32'h0, m_ifinstr});
    check("IF_ID_valid", {63'h0, IF_ID_valid}, {63'h0, m_ifvalid});
    @(posedge clk);
    rq = exp_req();
    mem_update(rq);
    model_update(rq);
    #1;
  endtask

  task automatic drive(input logic r, input logic pw, input logic iw, input logic fl,
                       input logic [63:0] tgt, input logic g, input logic rv,
                       input logic [31:0] rd);
    reset = r; PC_Write = pw; IF_ID_Write = iw; flush = fl;
    branch_target = tgt; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
  endtask

  initial begin
    drive(1, 1, 1, 0, 64'h0, 0, 0, 32'h0);
    cycle(); cycle();
    check("rst_valid", {63'h0, IF_ID_valid}, 64'h0);
    check("rst_instr", {32'h0, IF_ID_instr}, 64'h13);
    check("rst_pc",    IF_ID_pc,  64'h0);
    check("rst_addr",  imem_addr, 64'h0);

    // Basic fetch and delivery
    drive(0, 1, 1, 0, 64'h0, 1, 0, 32'h0); cycle();
    drive(0, 1, 1, 0, 64'h0, 0, 1, 32'h00A00093); cycle();
    check("t1_pc",    IF_ID_pc, 64'h0);
    check("t1_instr", {32'h0, IF_ID_instr}, 64'h00A00093);
    check("t1_valid", {63'h0, IF_ID_valid}, 64'h1);
    check("t1_addr",  imem_addr, 64'h4);

    // Response during a stall goes to the skid buffer
    drive(0, 1, 1, 0, 64'h0, 1, 0, 32'h0); cycle();
    drive(0, 0, 0, 0, 64'h0, 0, 1, 32'h00208133); cycle();
    drive(0, 0, 0, 0, 64'h0, 1, 0, 32'h0); #1;
    check("t2_req_stall", {63'h0, imem_req}, 64'h0);
    cycle();
    check("t2_hold_valid", {63'h0, IF_ID_valid}, 64'h0);
    check("t2_hold_pc",    IF_ID_pc, 64'h4);
    drive(0, 1, 1, 0, 64'h0, 0, 0, 32'h0); cycle();
    check("t2_pc",    IF_ID_pc, 64'h4);
    check("t2_instr", {32'h0, IF_ID_instr}, 64'h00208133);
    check("t2_valid", {63'h0, IF_ID_valid}, 64'h1);
    check("t2_addr",  imem_addr, 64'h8);

    // Flush while waiting: late response is discarded
    drive(0, 1, 1, 0, 64'h0, 1, 0, 32'h0); cycle();
    drive(0, 1, 1, 1, 64'h100, 0, 0, 32'h0); cycle();
    drive(0, 1, 1, 0, 64'h0, 0, 1, 32'hDEADBEEF); cycle();
    check("t3_valid", {63'h0, IF_ID_valid}, 64'h0);
    check("t3_instr", {32'h0, IF_ID_instr}, 64'h13);
    check("t3_addr",  imem_addr, 64'h100);

    // Grant withheld: request and address stay stable, bubbles flow
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 64'h0, 0, 0, 32'h0); #1;
      check("t4_req",  {63'h0, imem_req}, 64'h1);
      check("t4_addr", imem_addr, 64'h100);
      cycle();
      check("t4_valid", {63'h0, IF_ID_valid}, 64'h0);
      check("t4_instr", {32'h0, IF_ID_instr}, 64'h13);
    end
    drive(0, 1, 1, 0, 64'h0, 1, 0, 32'h0); cycle();
    drive(0, 1, 1, 0, 64'h0, 0, 1, 32'h00300193); cycle();
    check("t4_dpc",  IF_ID_pc, 64'h100);
    check("t4_addr2", imem_addr, 64'h104);

    // Flush beats stall and drops the skid buffer; target is word-aligned
    drive(0, 1, 1, 0, 64'h0, 1, 0, 32'h0); cycle();
    drive(0, 0, 0, 0, 64'h0, 0, 1, 32'h12345678); cycle();
    drive(0, 0, 0, 1, 64'h203, 0, 0, 32'h0); cycle();
    check("t5_valid", {63'h0, IF_ID_valid}, 64'h0);
    check("t5_instr", {32'h0, IF_ID_instr}, 64'h13);
    check("t5_pc",    IF_ID_pc, 64'h0);
    check("t5_addr",  imem_addr, 64'h200);
    drive(0, 1, 1, 0, 64'h0, 0, 0, 32'h0); cycle();
    check("t5_dropped", {63'h0, IF_ID_valid}, 64'h0);

    // Reset while waiting
    drive(0, 1, 1, 0, 64'h0, 1, 0, 32'h0); cycle();
    drive(1, 1, 1, 0, 64'h0, 0, 0, 32'h0); #1;
    check("t6_req_rst", {63'h0, imem_req}, 64'h0);
    cycle();
    check("t6_valid", {63'h0, IF_ID_valid}, 64'h0);
    check("t6_instr", {32'h0, IF_ID_instr}, 64'h13);
    check("t6_addr",  imem_addr, 64'h0);
    drive(0, 1, 1, 0, 64'h0, 0, 0, 32'h0); #1;
    check("t6_req_rel", {63'h0, imem_req}, 64'h1);
    cycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      PC_Write    = ($urandom_range(0, 3) != 0);
      IF_ID_Write = ($urandom_range(0, 3) != 0);
      imem_gnt    = $urandom_range(0, 1);
      if (mem_out && mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      flush = ($urandom_range(0, 9) == 0) && !(imem_rvalid && m_pending);
      if ($urandom_range(0, 3) == 0)
        branch_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        branch_target = {$urandom, $urandom};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV64 pipeline. It holds the PC and the IF/ID pipeline register, and it consumes PC_Write and IF_ID_Write from the hazard detection unit.
- It fetches from instruction memory over a request/grant/response handshake, with one request outstanding at a time.
- On a taken branch (flush) it redirects the PC, cancels any in-flight fetch and inserts bubbles.
- It feeds IF_ID_pc, IF_ID_instr and IF_ID_valid to decode and to the hazard unit (rs1/rs2 come from IF_ID_instr).

Parameters:
- XLEN, 64, width of PC and addresses.
- RESET_PC, 0, PC value after reset.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- PC_Write  input  1  hazard unit: PC may advance.
- IF_ID_Write  input  1  hazard unit: IF/ID may load.
- flush  input  1  branch taken, from EX/MEM.
- branch_target  input  XLEN  redirect PC, valid with flush.
- imem_req  output  1  fetch request.
- imem_addr  output  XLEN  fetch address (current PC).
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  fetched instruction.
- IF_ID_pc  output  XLEN  PC of the instruction in IF/ID.
- IF_ID_instr  output  32  instruction in IF/ID.
- IF_ID_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high, and sampled at the rising edge of clk.
- Reset values: pc=RESET_PC, state=FETCH, IF_ID_pc=0, IF_ID_instr=NOP_INSTR, IF_ID_valid=0, skid buffer empty. imem_req=0 during the reset cycle.
- Advance condition: adv = PC_Write & IF_ID_Write. If the two inputs differ, both are treated as 0 (stall).
- imem_req = (state==FETCH) & ~flush & ~reset.
- imem_addr = pc.
- Handshake: a request is accepted only when imem_req & imem_gnt. While imem_req is high and not yet granted, imem_addr is held stable.
- The response arrives at least 1 cycle after the grant. imem_rvalid is ignored in FETCH and HOLD.
- FETCH: on grant, go to WAIT.
- WAIT, on imem_rvalid:
  - If adv: IF/ID <= {pc, imem_rdata, 1}, pc <= pc+4, go to FETCH.
  - Otherwise: store {pc, rdata} in the skid buffer and go to HOLD.
- HOLD: when adv, IF/ID <= buffer with valid=1, pc <= pc+4, go to FETCH. IF/ID is held while adv=0.
- Bubbles: in any cycle where adv=1 and no instruction is delivered, IF/ID loads {pc, NOP_INSTR, 0}.
- Stall: adv=0 holds IF/ID and pc unchanged, except when flush is asserted.
- Flush has highest priority after reset and overrides adv:
  - IF/ID <= {0, NOP_INSTR, 0}.
  - pc <= {branch_target[XLEN-1:2], 2'b00}.
  - The skid buffer is dropped.
  - If state is WAIT, go to KILL. Otherwise go to FETCH; an ungranted request is withdrawn.
- KILL: the next imem_rvalid is discarded, then go to FETCH. A flush while in KILL updates pc; the state stays KILL if no rvalid arrived, or goes to FETCH if rvalid arrives in the same cycle.
- Arithmetic: pc+4 wraps modulo 2^XLEN.
- Throughput: at most 1 instruction per 2 cycles (grant cycle, then response cycle).
- Reset mid-operation: all state returns to reset values. Instruction memory shares the same reset, so no stale response is expected. The first request after reset targets RESET_PC.

Test Plan:
1. Release reset; imem_gnt=1 immediately; rvalid with rdata=0x00A00093 one cycle later, adv=1 -> IF_ID_pc=0, IF_ID_instr=0x00A00093, IF_ID_valid=1; next imem_addr=4.
2. rvalid with rdata=0x00208133 while IF_ID_Write=PC_Write=0 for 2 cycles -> IF/ID unchanged and imem_req=0 during the stall. On release, IF/ID gets PC 4 with 0x00208133, valid=1, and imem_addr becomes 8.
3. flush with branch_target=0x100 while in WAIT; next rvalid carries 0xDEADBEEF -> the data is discarded, IF_ID_valid=0, IF_ID_instr=0x13, next request at imem_addr=0x100.
4. imem_gnt held low for 3 cycles with adv=1 -> imem_req=1 and imem_addr stable throughout; IF/ID shows bubbles (valid=0, instr=0x13) each cycle.
5. flush with branch_target=0x203 in the same cycle as a stall and a HOLD buffer -> flush wins: IF/ID cleared, buffer dropped, next imem_addr=0x200.
6. reset asserted during WAIT -> next cycle all outputs are at reset values and imem_req=0; after release, the first request is at RESET_PC.
